// File: rtl/serial_to_parallel_rx.sv
// Receive-side deserialiser: aligns the 1-bit line stream on COM symbols and,
// once locked, emits one byte with a payload flag every 8 bit-clocks.
module serial_to_parallel_rx #(
    parameter logic [7:0] COM_SYMBOL     = 8'hBC,
    parameter int         COM_LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam int CW = $clog2(COM_LOCK_COUNT + 1);
    localparam logic [CW-1:0] LAST_COM = CW'(COM_LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t          r_state;
    // Only the 7 newest history bits are ever read; the 8th comes from data_in.
    logic [6:0]      r_sr;
    logic [2:0]      r_bit_cnt;
    logic [CW-1:0]   r_com_cnt;
    logic [7:0]      r_data_out;
    logic            r_valid_out;
    logic            r_byte_strobe;
    logic            r_active;

    logic [7:0]      w_win;
    logic            w_is_com;
    logic            w_boundary;

    assign w_win      = {r_sr, data_in};
    assign w_is_com   = (w_win == COM_SYMBOL);
    assign w_boundary = (r_bit_cnt == 3'd7);

    assign data_out    = r_data_out;
    assign valid_out   = r_valid_out;
    assign byte_strobe = r_byte_strobe;
    assign active      = r_active;

    // Shift register, bit counter, alignment/lock FSM and registered outputs.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state       <= SEARCH;
            r_sr          <= 7'd0;
            r_bit_cnt     <= 3'd0;
            r_com_cnt     <= '0;
            r_data_out    <= 8'd0;
            r_valid_out   <= 1'b0;
            r_byte_strobe <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_sr          <= w_win[6:0];
            r_bit_cnt     <= r_bit_cnt + 3'd1;
            r_byte_strobe <= 1'b0;
            case (r_state)
                SEARCH: begin
                    // Any COM in the window fixes byte alignment, whatever bit_cnt was.
                    if (w_is_com) begin
                        r_bit_cnt <= 3'd0;
                        r_com_cnt <= CW'(1);
                        r_state   <= COUNT;
                    end
                end
                COUNT: begin
                    if (w_boundary) begin
                        if (w_is_com) begin
                            if (r_com_cnt == LAST_COM) begin
                                r_state  <= ACTIVE;
                                r_active <= 1'b1;
                            end else begin
                                r_com_cnt <= r_com_cnt + CW'(1);
                            end
                        end else begin
                            r_com_cnt <= '0;
                            r_state   <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    if (w_boundary) begin
                        r_data_out    <= w_win;
                        r_valid_out   <= ~w_is_com;
                        r_byte_strobe <= 1'b1;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_to_parallel_rx.md
# serial_to_parallel_rx

Receive-side serial-to-parallel converter of the PHY lane. It deserialises the single-bit line stream and aligns byte boundaries on the COM symbol (0xBC). Once locked, it delivers one byte plus a valid flag every 8 bit-clocks to the 1x4 byte demux, which consumes them on its `data2send_to_LDMX` / `valid_out_to_LDMX` inputs.

## Interface
- `COM_SYMBOL`, 8'hBC: alignment/idle symbol.
- `COM_LOCK_COUNT`, 4: number of consecutive aligned COM symbols required to declare lock (range 2–15).
- `clk_32f`  input  1  bit clock; 8× the byte rate (`clk_4f`). All logic runs on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_in`  input  1  serial line bit, MSB first.
- `data_out`  output  8  aligned byte, held for 8 cycles.
- `valid_out`  output  1  `data_out` is a payload byte (not COM).
- `byte_strobe`  output  1  one-cycle pulse on the cycle `data_out` / `valid_out` update.
- `active`  output  1  lane aligned and locked.

## Operation
- Shift register: `sr[7:0] <= {sr[6:0], data_in}` every cycle.
- Combinational window: `w = {sr[6:0], data_in}`, which is the 8 most recent bits including the current one.
- Bit counter `bit_cnt[2:0]` increments mod 8 every cycle. A boundary cycle is one where `bit_cnt == 7`.
- COM counter `com_cnt` is wide enough for `COM_LOCK_COUNT`.
- FSM states: SEARCH, COUNT, ACTIVE.
- SEARCH: evaluated every cycle, not only at boundaries.
  - If `w == COM_SYMBOL`: `bit_cnt <= 0`, `com_cnt <= 1`, go to COUNT. This fixes byte alignment.
  - Otherwise stay in SEARCH.
- COUNT: evaluated on boundary cycles only.
  - `w == COM_SYMBOL` and `com_cnt == COM_LOCK_COUNT-1`: go to ACTIVE and set `active <= 1`.
  - `w == COM_SYMBOL` otherwise: `com_cnt++`.
  - `w != COM_SYMBOL`: `com_cnt <= 0`, return to SEARCH. Alignment is discarded; the search restarts on the next cycle.
- ACTIVE: evaluated on boundary cycles.
  - `data_out <= w`, `valid_out <= (w != COM_SYMBOL)`, `byte_strobe <= 1`.
  - Non-boundary cycles: `data_out` / `valid_out` hold and `byte_strobe <= 0`.
- ACTIVE is left only by `reset`; there is no loss-of-lock detection in this block.
- Outside ACTIVE, `data_out`, `valid_out` and `byte_strobe` stay 0.
- Reset values: state SEARCH, `sr` 0, `bit_cnt` 0, `com_cnt` 0, and all outputs 0.

## Timing
- Alignment latency: the cycle whose `data_in` completes the first COM loads `bit_cnt = 0`. Each subsequent aligned byte ends exactly 8 cycles later.
- Lock: `active` rises on the edge that samples the last bit of the `COM_LOCK_COUNT`-th consecutive aligned COM. It rises 8×(`COM_LOCK_COUNT`−1) cycles after the first COM completed. That COM itself is not emitted on `data_out`.
- Data latency: a byte's last bit sampled on edge N appears on `data_out` after edge N (registered, 1-cycle latency). It is held through edge N+7. `byte_strobe` is high for cycle N only.
- Downstream samples with `clk_4f`. `data_out` is stable for 8 `clk_32f` cycles, so any `clk_4f` phase sees exactly one value per byte.
- Reset mid-operation: the next edge with `reset = 1` clears everything, including `active`. Relock requires a fresh `COM_LOCK_COUNT` COM sequence.
- Simultaneous events: `reset` overrides all FSM transitions. In SEARCH, a COM match overrides the free-running `bit_cnt` value.
- Misaligned COM patterns inside payload during ACTIVE are ignored; only boundary windows are sampled.

## Test plan
- Reset: hold `reset` 3 cycles with random `data_in` -> all outputs 0, state SEARCH after each reset edge.
- Lock: 3 random bits, then 4× 0xBC, then 0x55 -> `active` rises on the edge of the last bit of the 4th BC. `data_out = 0x55` and `valid_out = 1` one cycle after its last bit, held 8 cycles, with `byte_strobe` pulsing once.
- Broken sequence: 0xBC, 0xBC, 0x12, then 4× 0xBC, then 0xA7 -> no lock after 0x12 (returns to SEARCH). Lock after the later 4 BCs; `data_out = 0xA7`, `valid_out = 1`.
- Idle in ACTIVE: locked lane receives 0x01, 0xBC, 0xFF -> `data_out` 0x01 (v=1), 0xBC (v=0), 0xFF (v=1) at 8-cycle spacing.
- Bit-slip search: prefix 5 bits then 4× 0xBC -> lock at the correct offset. A payload byte stream of 0x5E, 0x2F (containing no aligned BC) then passes unchanged.
- Reset mid-ACTIVE: assert `reset` during payload -> `active`, `data_out`, `valid_out` are 0 next edge. After reset, payload without COMs never sets `active`.
